// File: rtl/rot_pkg.sv
// Shared constants and types for the rotate arbiter.
//   DATA_W  : width of the rotated word
//   SHIFT_W : width of a rotate amount
//   NREQ    : number of requesters sharing the rotator
//   op_t    : one captured operation (operand, amount, direction, issuer)
package rot_pkg;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 5;
    localparam int NREQ    = 2;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHIFT_W-1:0] shift;
        logic               right;
        logic               id;
    } op_t;

endpackage

// File: rtl/rot32_core.sv
// Combinational 32-bit rotator.
//   data_i   : word to rotate
//   shift_i  : rotate amount, 0..31
//   right_i  : 1 = rotate right, 0 = rotate left
//   result_o : rotated word
module rot32_core
    import rot_pkg::*;
(
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic               right_i,
    output logic [DATA_W-1:0]  result_o
);

    // Shifting a doubled copy of the word turns the wrap-around into a plain
    // shift: the low half after a right shift and the high half after a left
    // shift are exactly the rotated word, including the zero-amount case.
    logic [2*DATA_W-1:0] dbl;
    logic [2*DATA_W-1:0] shr;
    logic [2*DATA_W-1:0] shl;

    assign dbl = {data_i, data_i};
    assign shr = dbl >> shift_i;
    assign shl = dbl << shift_i;

    assign result_o = right_i ? shr[DATA_W-1:0] : shl[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/rot_arbiter.sv
// Two requesters share one rotator through a two-stage pipeline.
//   RR_EN     : 1 = round-robin between requesters, 0 = requester 0 always wins
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   req_valid : per-requester request
//   req_ready : per-requester acceptance (at most one bit high)
//   req_data  : operands, [31:0] requester 0, [63:32] requester 1
//   req_shift : rotate amounts, [4:0] requester 0, [9:5] requester 1
//   req_right : per-requester direction, 1 = right
//   out_valid : result available
//   out_ready : consumer accepts result
//   out_data  : rotated word
//   out_id    : requester that issued the result
module rot_arbiter
    import rot_pkg::*;
#(
    parameter int RR_EN = 1
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*DATA_W-1:0]    req_data,
    input  logic [NREQ*SHIFT_W-1:0]   req_shift,
    input  logic [NREQ-1:0]           req_right,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_id
);

    logic              valid_a_q, valid_a_d;
    logic              valid_b_q, valid_b_d;
    logic              rr_ptr_q,  rr_ptr_d;
    op_t               op_a_q;
    logic [DATA_W-1:0] data_b_q;
    logic              id_b_q;

    logic              adv_a;
    logic              can_acc;
    logic              gnt_id;
    logic              acc;
    op_t               op_sel;
    logic [DATA_W-1:0] rot_res;

    assign adv_a   = valid_a_q & (~valid_b_q | out_ready);
    assign can_acc = ~valid_a_q | adv_a;

    always_comb begin
        gnt_id = 1'b0;
        case (req_valid)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = (RR_EN != 0) ? rr_ptr_q : 1'b0;
            default: gnt_id = 1'b0;
        endcase
    end

    // Ready is held low during reset even though the emptied stage A would
    // otherwise advertise room.
    always_comb begin
        req_ready = '0;
        if (rst_n && can_acc && req_valid[gnt_id]) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign acc = |req_ready;

    always_comb begin
        op_sel.data  = gnt_id ? req_data[2*DATA_W-1:DATA_W]    : req_data[DATA_W-1:0];
        op_sel.shift = gnt_id ? req_shift[2*SHIFT_W-1:SHIFT_W] : req_shift[SHIFT_W-1:0];
        op_sel.right = gnt_id ? req_right[1] : req_right[0];
        op_sel.id    = gnt_id;
    end

    // A fresh acceptance refills stage A even while it drains; stage B only
    // empties when the consumer takes it and nothing moves in behind.
    always_comb begin
        valid_a_d = valid_a_q;
        if (acc) begin
            valid_a_d = 1'b1;
        end else if (adv_a) begin
            valid_a_d = 1'b0;
        end

        valid_b_d = valid_b_q;
        if (adv_a) begin
            valid_b_d = 1'b1;
        end else if (out_ready) begin
            valid_b_d = 1'b0;
        end

        rr_ptr_d = acc ? ~gnt_id : rr_ptr_q;
    end

    // ---- stage A: captured operation ----
    always_ff @(posedge clk) begin
        if (acc) begin
            op_a_q <= op_sel;
        end
    end

    rot32_core u_rot (
        .data_i   (op_a_q.data),
        .shift_i  (op_a_q.shift),
        .right_i  (op_a_q.right),
        .result_o (rot_res)
    );

    // ---- stage B: registered result and pipeline control ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            rr_ptr_q  <= 1'b0;
            data_b_q  <= '0;
            id_b_q    <= 1'b0;
        end else begin
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
            rr_ptr_q  <= rr_ptr_d;
            if (adv_a) begin
                data_b_q <= rot_res;
                id_b_q   <= op_a_q.id;
            end
        end
    end

    assign out_valid = valid_b_q;
    assign out_data  = data_b_q;
    assign out_id    = id_b_q;

endmodule

// File: tb/tb_rot_arbiter.sv
module tb_rot_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [63:0] req_data = 64'h0;
    logic [9:0]  req_shift = 10'h0;
    logic [1:0]  req_right = 2'b00;
    logic        out_ready = 1'b0;

    logic [1:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;

    logic [1:0]  fp_ready;
    logic        fp_valid;
    logic [31:0] fp_data;
    logic        fp_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rot_arbiter #(.RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .req_right(req_right),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id)
    );

    rot_arbiter #(.RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(fp_ready),
        .req_data(req_data), .req_shift(req_shift), .req_right(req_right),
        .out_valid(fp_valid), .out_ready(out_ready),
        .out_data(fp_data), .out_id(fp_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int r, input logic [31:0] d, input logic [4:0] s, input logic rt);
        if (r == 0) begin
            req_data[31:0] = d;
            req_shift[4:0] = s;
            req_right[0]   = rt;
        end else begin
            req_data[63:32] = d;
            req_shift[9:5]  = s;
            req_right[1]    = rt;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_id, out_data, req_ready} !== {1'b0, 1'b0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_rr: got v=%b id=%b d=%h rdy=%b want 0 0 00000000 00", out_valid, out_id, out_data, req_ready);
        end
        n_checks++;
        if ({fp_valid, fp_id, fp_data, fp_ready} !== {1'b0, 1'b0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_fp: got v=%b id=%b d=%h rdy=%b want 0 0 00000000 00", fp_valid, fp_id, fp_data, fp_ready);
        end
        step();
        step();
        n_checks++;
        if ({out_valid, req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_clocked: got v=%b rdy=%b want 0 00", out_valid, req_ready);
        end
        req_valid = 2'b00;
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_r0();
        do_reset();
        set_op(0, 32'h80000001, 5'd1, 1'b1);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL r0_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_early: out_valid got %b want 0", out_valid);
        end
        step();
        n_checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 32'hC0000000}) begin
            n_fail++;
            $display("FAIL r0_result: got v=%b id=%b d=%h want 1 0 c0000000", out_valid, out_id, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_r1();
        do_reset();
        set_op(1, 32'h12345678, 5'd4, 1'b0);
        req_valid = 2'b10;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL r1_ready: got %b want 10", req_ready);
        end
        step();
        set_op(1, 32'hDEADBEEF, 5'd0, 1'b0);
        step();
        req_valid = 2'b00;
        n_checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 32'h23456781}) begin
            n_fail++;
            $display("FAIL r1_rotl4: got v=%b id=%b d=%h want 1 1 23456781", out_valid, out_id, out_data);
        end
        step();
        n_checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL r1_rotl0: got v=%b id=%b d=%h want 1 1 deadbeef", out_valid, out_id, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r1_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    // Both requesters valid for six acceptances; r0 rotates FF right by 8,
    // r1 rotates 0F0F0000 left by 4.
    task automatic test_back_to_back();
        logic [1:0]  exp_rdy;
        logic        exp_id;
        logic [31:0] exp_d;
        do_reset();
        set_op(0, 32'h000000FF, 5'd8, 1'b1);
        set_op(1, 32'h0F0F0000, 5'd4, 1'b0);
        out_ready = 1'b1;
        req_valid = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k <= 6) begin
                exp_rdy = ((k - 1) % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if (req_ready !== exp_rdy) begin
                    n_fail++;
                    $display("FAIL b2b_rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
                end
                n_checks++;
                if (fp_ready !== 2'b01) begin
                    n_fail++;
                    $display("FAIL b2b_fp_ready[%0d]: got %b want 01", k, fp_ready);
                end
            end
            step();
            if (k == 6) req_valid = 2'b00;
            if (k >= 2 && k <= 7) begin
                exp_id = ((k - 2) % 2 == 1);
                exp_d  = exp_id ? 32'hF0F00000 : 32'hFF000000;
                n_checks++;
                if ({out_valid, out_id, out_data} !== {1'b1, exp_id, exp_d}) begin
                    n_fail++;
                    $display("FAIL b2b_rr_out[%0d]: got v=%b id=%b d=%h want 1 %b %h", k - 2, out_valid, out_id, out_data, exp_id, exp_d);
                end
                n_checks++;
                if ({fp_valid, fp_id, fp_data} !== {1'b1, 1'b0, 32'hFF000000}) begin
                    n_fail++;
                    $display("FAIL b2b_fp_out[%0d]: got v=%b id=%b d=%h want 1 0 ff000000", k - 2, fp_valid, fp_id, fp_data);
                end
            end
        end
        n_checks++;
        if ({out_valid, fp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_drain: got rr=%b fp=%b want 0 0", out_valid, fp_valid);
        end
    endtask

    // Three left rotates of 1 (by 1, 2, 3) with the consumer stalled.
    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        set_op(0, 32'h00000001, 5'd1, 1'b0);
        req_valid = 2'b01;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_acc0: got %b want 01", req_ready);
        end
        step();
        set_op(0, 32'h00000001, 5'd2, 1'b0);
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_acc1: got %b want 01", req_ready);
        end
        step();
        set_op(0, 32'h00000001, 5'd3, 1'b0);
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({req_ready, out_valid, out_id, out_data} !== {2'b00, 1'b1, 1'b0, 32'h00000002}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%b d=%h want 00 1 0 00000002", c, req_ready, out_valid, out_id, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, out_data} !== {2'b01, 32'h00000002}) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b d=%h want 01 00000002", req_ready, out_data);
        end
        step();
        req_valid = 2'b00;
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h00000004}) begin
            n_fail++;
            $display("FAIL bp_out1: got v=%b d=%h want 1 00000004", out_valid, out_data);
        end
        step();
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 32'h00000008}) begin
            n_fail++;
            $display("FAIL bp_out2: got v=%b d=%h want 1 00000008", out_valid, out_data);
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b0;
        set_op(0, 32'hA5A5A5A5, 5'd0, 1'b0);
        req_valid = 2'b01;
        step();
        step();
        n_checks++;
        if ({out_valid, req_ready} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL mid_full: got v=%b rdy=%b want 1 00", out_valid, req_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_id, out_data, req_ready} !== {1'b0, 1'b0, 32'h0, 2'b00}) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b id=%b d=%h rdy=%b want 0 0 00000000 00", out_valid, out_id, out_data, req_ready);
        end
        req_valid = 2'b00;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if ({out_valid, fp_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_stale[%0d]: got rr=%b fp=%b want 0 0", c, out_valid, fp_valid);
            end
        end
        set_op(0, 32'h00000010, 5'd4, 1'b1);
        set_op(1, 32'h00000010, 5'd4, 1'b0);
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_ptr: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        n_checks++;
        if ({out_valid, out_id, out_data} !== {1'b1, 1'b0, 32'h00000001}) begin
            n_fail++;
            $display("FAIL mid_after: got v=%b id=%b d=%h want 1 0 00000001", out_valid, out_id, out_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_r0();
        test_single_r1();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
